// File: rtl/demux_2_16b_reg_if.sv
// Bundle of the producer-side and consumer-side handshake signals of the
// registered 1-to-4 demultiplexer.
interface demux_2_16b_reg_if #(
  parameter int COUNT_W = 8
);
  logic [15:0]        in_value;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        out_value0;
  logic [15:0]        out_value1;
  logic [15:0]        out_value2;
  logic [15:0]        out_value3;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [COUNT_W-1:0] out_count0;
  logic [COUNT_W-1:0] out_count1;
  logic [COUNT_W-1:0] out_count2;
  logic [COUNT_W-1:0] out_count3;

  modport slave (
    input  in_value, in_sel, in_valid, out_ready,
    output in_ready, out_value0, out_value1, out_value2, out_value3,
           out_valid, out_count0, out_count1, out_count2, out_count3
  );

  modport master (
    output in_value, in_sel, in_valid, out_ready,
    input  in_ready, out_value0, out_value1, out_value2, out_value3,
           out_valid, out_count0, out_count1, out_count2, out_count3
  );
endinterface

// File: rtl/demux_2_16b_reg.sv
// Registered 1-to-4 demultiplexer: one holding register and valid flag per
// channel, valid/ready on the input and on every output, per-channel counters.
module demux_2_16b_reg #(
  parameter int COUNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  demux_2_16b_reg_if.slave  bus
);
  localparam int DATA_W = 16;

  logic [DATA_W-1:0]  value_p1 [4];
  logic [3:0]         vld_p1;
  logic [COUNT_W-1:0] cnt_p1 [4];
  logic               in_ready_c;
  logic               take_in;
  logic [3:0]         take_out;

  function automatic logic [COUNT_W-1:0] wrap_inc(input logic [COUNT_W-1:0] c);
    return c + COUNT_W'(1);
  endfunction

  // Ready looks only at the addressed channel, so a stalled channel never blocks the others.
  always_comb begin
    in_ready_c = 1'b0;
    if (!reset)
      in_ready_c = ~vld_p1[bus.in_sel] | bus.out_ready[bus.in_sel];
  end

  assign take_in  = bus.in_valid & in_ready_c;
  assign take_out = vld_p1 & bus.out_ready;

  // Stage p1: holding registers, valid flags and delivered-word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        value_p1[k] <= '0;
        cnt_p1[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (take_in && (bus.in_sel == 2'(k))) begin
          value_p1[k] <= bus.in_value;
          vld_p1[k]   <= 1'b1;
        end else if (take_out[k]) begin
          vld_p1[k]   <= 1'b0;
        end
        if (take_out[k])
          cnt_p1[k] <= wrap_inc(cnt_p1[k]);
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = vld_p1;
  assign bus.out_value0 = value_p1[0];
  assign bus.out_value1 = value_p1[1];
  assign bus.out_value2 = value_p1[2];
  assign bus.out_value3 = value_p1[3];
  assign bus.out_count0 = cnt_p1[0];
  assign bus.out_count1 = cnt_p1[1];
  assign bus.out_count2 = cnt_p1[2];
  assign bus.out_count3 = cnt_p1[3];
endmodule
